fp_mul_sequencer: RTL
=====================

FP_MUL_SEQUENCER -- requirements
Module: fp_mul_sequencer

Interface
REQ-001 SHALL have parameter Mantissa_Size, default 23, mantissa field width.
REQ-002 SHALL have parameter Exponent_Size, default 8, exponent field width; N = Mantissa_Size+Exponent_Size (operand width N+1).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, operand-pair queue entries (power of two, >=2).
REQ-004 SHALL have parameter MUL_LATENCY, default 2, cycles from load pulse to valid multiplier outputs (>=1).
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, in_a input N+1, in_b input N+1: operand-pair push handshake.
REQ-008 SHALL have ports mul_enable output 1, mul_load output 1, mul_a output N+1, mul_b output N+1: drive to the downstream multiplier.
REQ-009 SHALL have ports mul_result input N+1, mul_overflow input 1, mul_zero input 1: multiplier outputs.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, out_result output N+1, out_overflow output 1, out_zero output 1: result handshake.
REQ-011 SHALL have port busy, output, 1, high whenever state != IDLE or FIFO non-empty.

Function
REQ-012 Push SHALL occur on a cycle with in_valid && in_ready; in_ready = FIFO not full, registered, no same-cycle fall-through when full even if a pop occurs.
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-014 IDLE -> ISSUE when FIFO non-empty; ISSUE lasts exactly one cycle, pops FIFO head into mul_a/mul_b, asserts mul_enable and mul_load high for that cycle only.
REQ-015 mul_a/mul_b SHALL hold the issued pair stable from ISSUE until leaving WAIT; mul_enable, mul_load SHALL be low in all other states.
REQ-016 WAIT SHALL count MUL_LATENCY cycles (counter width clog2(MUL_LATENCY)+1), then register mul_result, mul_overflow, mul_zero into out_* and enter HOLD.
REQ-017 HOLD SHALL assert out_valid with out_* stable; on out_ready go to ISSUE if FIFO non-empty, else IDLE.
REQ-018 Minimum latency push-to-out_valid SHALL be 1 (FIFO write) + 1 (ISSUE) + MUL_LATENCY cycles; results SHALL leave in push order.
REQ-019 FIFO SHALL wrap read/write pointers modulo FIFO_DEPTH with an occupancy count distinguishing full from empty.

Reset
REQ-020 rst SHALL asynchronously force state IDLE, FIFO empty, counter 0, in_ready 1, out_valid 0, out_result 0, out_overflow 0, out_zero 0, mul_enable 0, mul_load 0, mul_a 0, mul_b 0, busy 0.
REQ-021 rst asserted in ISSUE/WAIT/HOLD SHALL discard the in-flight pair and all queued pairs; late multiplier outputs SHALL be ignored.

Configuration
REQ-022 Macro FP_SEQ_ZERO_BYPASS_EN defined: in ISSUE, a pair where either operand has all exponent and mantissa bits zero (sign ignored) SHALL not pulse mul_enable/mul_load and SHALL go directly to HOLD next cycle with out_result 0, out_zero 1, out_overflow 0.
REQ-023 Macro undefined: every pair SHALL pass through the multiplier per REQ-014..016.

Structure
REQ-024 Package fp_seq_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, HOLD) and field-width constants.
REQ-025 Queue SHALL be a sub-module fp_seq_fifo (parameterised width 2*(N+1), depth FIFO_DEPTH).

Verification
REQ-026 Push A=32'h3FC00000, B=32'h40000000, model returns 32'h40400000 after 2 cycles -> mul_load high exactly 1 cycle, out_valid 4 cycles after push, out_result 32'h40400000.
REQ-027 out_ready held 0, push 6 pairs back-to-back -> 5 accepted (1 in HOLD + 4 queued), in_ready low on 6th; then out_ready 1 -> 5 results in push order.
REQ-028 Assert rst during WAIT of pair 2 of 3 queued -> all outputs at reset values same cycle; no out_valid afterward without new push.
REQ-029 With FP_SEQ_ZERO_BYPASS_EN, push A=32'h80000000, B=32'h3F800000 -> no mul_load pulse, out_result 0, out_zero 1, out_overflow 0; without macro -> mul_load pulses, model result forwarded.
REQ-030 Model drives mul_overflow 1 for A=B=32'h7F000000 -> out_overflow 1, held in HOLD until out_ready.

Source files
------------

// File: rtl/fp_seq_pkg.sv
// rtl/fp_seq_pkg.sv - sequencer state encoding and default field widths
package fp_seq_pkg;

  localparam int DEF_MANTISSA_SIZE = 23;
  localparam int DEF_EXPONENT_SIZE = 8;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_MUL_LATENCY   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Latency counter width: enough to hold MUL_LATENCY itself.
  function automatic int cnt_width(input int latency);
    return $clog2(latency) + 1;
  endfunction

endpackage

// File: rtl/fp_mul_sequencer_if.sv
// rtl/fp_mul_sequencer_if.sv - operand push, multiplier and result handshake bundle
interface fp_mul_sequencer_if
  import fp_seq_pkg::*;
#(
  parameter int Mantissa_Size = DEF_MANTISSA_SIZE,
  parameter int Exponent_Size = DEF_EXPONENT_SIZE
);
  localparam int W = Mantissa_Size + Exponent_Size + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  logic         mul_enable;
  logic         mul_load;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [W-1:0] mul_result;
  logic         mul_overflow;
  logic         mul_zero;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_overflow;
  logic         out_zero;

  logic         busy;

  modport master (
    input  in_valid, in_a, in_b,
    output in_ready,
    output mul_enable, mul_load, mul_a, mul_b,
    input  mul_result, mul_overflow, mul_zero,
    output out_valid, out_result, out_overflow, out_zero,
    input  out_ready,
    output busy
  );

  modport slave (
    output in_valid, in_a, in_b,
    input  in_ready,
    input  mul_enable, mul_load, mul_a, mul_b,
    output mul_result, mul_overflow, mul_zero,
    input  out_valid, out_result, out_overflow, out_zero,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/fp_seq_fifo.sv
// rtl/fp_seq_fifo.sv - operand-pair queue with wrapping pointers and registered full flag
module fp_seq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_next;

  // Writes are refused while full even if a pop happens in the same cycle.
  assign w_push       = i_push && !r_full;
  assign w_pop        = i_pop && (r_count != '0);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = r_full;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/fp_mul_sequencer.sv
// rtl/fp_mul_sequencer.sv - issues queued operand pairs to an FP multiplier; option FP_SEQ_ZERO_BYPASS_EN
module fp_mul_sequencer
  import fp_seq_pkg::*;
#(
  parameter int Mantissa_Size = DEF_MANTISSA_SIZE,
  parameter int Exponent_Size = DEF_EXPONENT_SIZE,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int MUL_LATENCY   = DEF_MUL_LATENCY
) (
  input logic                clk,
  input logic                rst,
  fp_mul_sequencer_if.master bus
);
  localparam int N     = Mantissa_Size + Exponent_Size;
  localparam int W     = N + 1;
  localparam int CNT_W = cnt_width(MUL_LATENCY);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mul_enable;
  logic             r_mul_load;
  logic [W-1:0]     r_mul_a;
  logic [W-1:0]     r_mul_b;
  logic             r_out_valid;
  logic [W-1:0]     r_out_result;
  logic             r_out_overflow;
  logic             r_out_zero;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [2*W-1:0]   w_head;
  logic [W-1:0]     w_head_a;
  logic [W-1:0]     w_head_b;

`ifdef FP_SEQ_ZERO_BYPASS_EN
  logic             r_bypass;
  logic             w_head_zero;
  // Sign bit is ignored: +0 and -0 both short-circuit the multiplier.
  assign w_head_zero = (w_head_a[N-1:0] == '0) || (w_head_b[N-1:0] == '0);
`endif

  assign w_push   = bus.in_valid && !w_full;
  assign w_head_a = w_head[2*W-1:W];
  assign w_head_b = w_head[W-1:0];
  // A new pair is issued from IDLE, or straight out of HOLD once the result is taken.
  assign w_pop    = !w_empty && ((r_state == IDLE) || ((r_state == HOLD) && bus.out_ready));

  fp_seq_fifo #(
    .WIDTH (2*W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({bus.in_a, bus.in_b}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign bus.in_ready     = !w_full;
  assign bus.mul_enable   = r_mul_enable;
  assign bus.mul_load     = r_mul_load;
  assign bus.mul_a        = r_mul_a;
  assign bus.mul_b        = r_mul_b;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_result   = r_out_result;
  assign bus.out_overflow = r_out_overflow;
  assign bus.out_zero     = r_out_zero;
  assign bus.busy         = (r_state != IDLE) || !w_empty;

  // Sequencer FSM with registered multiplier drive and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_mul_enable   <= 1'b0;
      r_mul_load     <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_overflow <= 1'b0;
      r_out_zero     <= 1'b0;
`ifdef FP_SEQ_ZERO_BYPASS_EN
      r_bypass       <= 1'b0;
`endif
    end else begin
      r_mul_enable <= 1'b0;
      r_mul_load   <= 1'b0;
      case (r_state)
        IDLE: r_cnt <= '0;
        ISSUE: begin
`ifdef FP_SEQ_ZERO_BYPASS_EN
          if (r_bypass) begin
            r_out_result   <= '0;
            r_out_overflow <= 1'b0;
            r_out_zero     <= 1'b1;
            r_out_valid    <= 1'b1;
            r_state        <= HOLD;
          end else
`endif
          begin
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(MUL_LATENCY - 1)) begin
            r_out_result   <= bus.mul_result;
            r_out_overflow <= bus.mul_overflow;
            r_out_zero     <= bus.mul_zero;
            r_out_valid    <= 1'b1;
            r_state        <= HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // Issuing overrides the case above: it moves the FSM into ISSUE for one cycle.
      if (w_pop) begin
        r_mul_a <= w_head_a;
        r_mul_b <= w_head_b;
        r_state <= ISSUE;
`ifdef FP_SEQ_ZERO_BYPASS_EN
        r_bypass     <= w_head_zero;
        r_mul_enable <= !w_head_zero;
        r_mul_load   <= !w_head_zero;
`else
        r_mul_enable <= 1'b1;
        r_mul_load   <= 1'b1;
`endif
      end
    end
  end

endmodule
